// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/fill path: geometry, FSM and owner
// encodings, and address field helpers.
package cache_pkg;

  localparam int ADDR_W  = 16;
  localparam int WORDS   = 8;
  localparam int INDEX_W = 7;
  localparam int TAG_W   = ADDR_W - INDEX_W - 4;
  localparam int OFS_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } fill_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  function automatic logic [INDEX_W-1:0] addr_set(input logic [ADDR_W-1:0] a);
    return a[INDEX_W+3:4];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:INDEX_W+4];
  endfunction

  // Byte address of 16-bit word w inside the 16-byte block containing a.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [OFS_W-1:0]  w);
    return {a[ADDR_W-1:4], w, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_word_cnt.sv
// 3-bit word counter with enable and asynchronous clear; wrap flags the last
// word of a block so the owner knows the next increment rolls over.
module word_cnt
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OFS_W-1:0] cnt,
  output logic             wrap
);

  logic [OFS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + OFS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == OFS_W'(WORDS - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Serializes I-cache and D-cache block fills onto one pipelined memory read
// port and steers returning words into the owning cache's arrays.
module cache_fill_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_miss,
  input  logic [ADDR_W-1:0]  i_miss_addr,
  input  logic               d_miss,
  input  logic [ADDR_W-1:0]  d_miss_addr,
  input  logic               mem_data_valid,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               fill_owner,
  output logic [INDEX_W-1:0] fill_set,
  output logic               data_wr_en,
  output logic [OFS_W-1:0]   data_wr_word,
  output logic               tag_wr_en,
  output logic [TAG_W-1:0]   fill_tag,
  output logic               i_stall,
  output logic               d_stall,
  output logic               i_fill_done,
  output logic               d_fill_done
);

  fill_state_e       state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              grant_d;

  logic              issue_en, ret_en;
  logic [OFS_W-1:0]  issue_cnt, ret_cnt;
  logic              issue_wrap, ret_wrap;
  logic              in_fill;

  assign in_fill = (state_q == FILL);
  assign issue_en = in_fill && rd_en_q;
  assign ret_en   = in_fill && mem_data_valid;

  word_cnt u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .wrap  (issue_wrap)
  );

  word_cnt u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ret_en),
    .cnt   (ret_cnt),
    .wrap  (ret_wrap)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    rd_en_d  = rd_en_q;
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    // D wins a tie unless it won the previous grant, so neither side starves.
    grant_d  = d_miss && (!i_miss || (last_q == OWN_I));
    case (state_q)
      IDLE: begin
        if (i_miss || d_miss) begin
          owner_d = grant_d ? OWN_D : OWN_I;
          addr_d  = grant_d ? d_miss_addr : i_miss_addr;
          rd_en_d = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (rd_en_q && issue_wrap) rd_en_d = 1'b0;
        // Completion counts returned words, so any memory latency works.
        if (mem_data_valid && ret_wrap) begin
          i_done_d = (owner_q == OWN_I);
          d_done_d = (owner_q == OWN_D);
          state_d  = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      last_q   <= OWN_I;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = word_addr(addr_q, issue_cnt);
  assign fill_owner   = owner_q;
  assign fill_set     = addr_set(addr_q);
  assign fill_tag     = addr_tag(addr_q);
  assign data_wr_en   = ret_en;
  assign data_wr_word = ret_cnt;
  assign tag_wr_en    = ret_en && ret_wrap;
  assign i_fill_done  = i_done_q;
  assign d_fill_done  = d_done_q;
  assign i_stall      = i_miss && !i_done_q;
  assign d_stall      = d_miss && !d_done_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a latency-programmable memory model.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_miss = 1'b0;
  logic [ADDR_W-1:0]  i_miss_addr = '0;
  logic               d_miss = 1'b0;
  logic [ADDR_W-1:0]  d_miss_addr = '0;
  wire                mem_data_valid;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic               fill_owner;
  logic [INDEX_W-1:0] fill_set;
  logic               data_wr_en;
  logic [OFS_W-1:0]   data_wr_word;
  logic               tag_wr_en;
  logic [TAG_W-1:0]   fill_tag;
  logic               i_stall, d_stall, i_fill_done, d_fill_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 4;
  int t0 = 0;
  logic spur = 1'b0;
  logic pipe_vld = 1'b0;
  logic [15:0] sr = '0;

  cache_fill_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .mem_data_valid (mem_data_valid),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .fill_owner     (fill_owner),
    .fill_set       (fill_set),
    .data_wr_en     (data_wr_en),
    .data_wr_word   (data_wr_word),
    .tag_wr_en      (tag_wr_en),
    .fill_tag       (fill_tag),
    .i_stall        (i_stall),
    .d_stall        (d_stall),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done)
  );

  always #5 clk = ~clk;

  // Memory: a request seen in cycle c returns a valid in cycle c+lat.
  assign mem_data_valid = pipe_vld | spur;
  always @(posedge clk) begin
    #1;
    sr = {sr[14:0], mem_rd_en};
    pipe_vld = sr[lat];
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"},  mem_rd_en, 0);
    chk({tag, "_addr"},   mem_addr, 0);
    chk({tag, "_owner"},  fill_owner, 0);
    chk({tag, "_set"},    fill_set, 0);
    chk({tag, "_tag"},    fill_tag, 0);
    chk({tag, "_wr_en"},  data_wr_en, 0);
    chk({tag, "_word"},   data_wr_word, 0);
    chk({tag, "_tag_wr"}, tag_wr_en, 0);
    chk({tag, "_done"},   {i_fill_done, d_fill_done}, 0);
    chk({tag, "_stall"},  {i_stall, d_stall}, 0);
  endtask

  // Caller is in cycle 0 (IDLE, miss visible); returns in the DONE cycle with
  // the owner's miss dropped.
  task automatic fill_run(input logic own, input logic [ADDR_W-1:0] a, input int l);
    int done_c;
    int nv;
    done_c = l + 9;
    nv = 0;
    for (int c = 1; c <= done_c; c++) begin
      tick();
      chk("rd_en", mem_rd_en, (c <= 8));
      if (c <= 8) chk("mem_addr", mem_addr, {a[15:4], 4'h0} + 2 * (c - 1));
      chk("wr_en", data_wr_en, (c > l) && (c <= l + 8));
      if (data_wr_en === 1'b1) begin
        chk("wr_word", data_wr_word, nv);
        nv++;
      end
      chk("tag_wr", tag_wr_en, (c == l + 8));
      chk("i_done", i_fill_done, (c == done_c) && !own);
      chk("d_done", d_fill_done, (c == done_c) && own);
      chk("owner", fill_owner, own);
      chk("set", fill_set, (a >> 4) & 16'h7F);
      chk("ftag", fill_tag, a >> 11);
      chk("own_stall", own ? d_stall : i_stall, (c != done_c));
      chk("oth_stall", own ? i_stall : d_stall, own ? i_miss : d_miss);
    end
    chk("n_writes", nv, 8);
    if (own) d_miss = 1'b0;
    else     i_miss = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk_zero("rst");
    #10 rst_n = 1'b1;
    tick();
    tick();

    // Single I miss at 0x1234, 4-cycle memory
    i_miss_addr = 16'h1234;
    i_miss = 1'b1;
    #1;
    chk("c0_i_stall", i_stall, 1);
    chk("c0_rd_en", mem_rd_en, 0);
    fill_run(OWN_I, 16'h1234, 4);
    tick();
    chk("idle_rd_en", mem_rd_en, 0);
    chk("idle_i_stall", i_stall, 0);

    // Simultaneous I (0x0040) and D (0x8F00) from reset: D first
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    i_miss_addr = 16'h0040;
    d_miss_addr = 16'h8F00;
    i_miss = 1'b1;
    d_miss = 1'b1;
    t0 = cyc;
    fill_run(OWN_D, 16'h8F00, 4);
    chk("d_done_cyc", cyc - t0, 13);
    chk("d_fill_set", fill_set, 7'h70);
    chk("d_fill_tag", fill_tag, 5'h11);
    tick();
    chk("i_wait_stall", i_stall, 1);
    fill_run(OWN_I, 16'h0040, 4);
    chk("i_done_cyc", cyc - t0, 27);
    tick();

    // D back-to-back with I held: grants alternate D, I, D
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    i_miss_addr = 16'h0100;
    d_miss_addr = 16'h2000;
    i_miss = 1'b1;
    d_miss = 1'b1;
    fill_run(OWN_D, 16'h2000, 4);
    tick();
    d_miss_addr = 16'h3000;
    d_miss = 1'b1;
    fill_run(OWN_I, 16'h0100, 4);
    tick();
    i_miss = 1'b1;
    fill_run(OWN_D, 16'h3000, 4);
    tick();
    i_miss = 1'b0;
    tick();

    // Latency sweep with a spurious valid in IDLE before each fill
    for (int k = 0; k < 3; k++) begin
      lat = (k == 0) ? 1 : (k == 1) ? 4 : 7;
      spur = 1'b1;
      #1;
      chk("spur_wr_en", data_wr_en, 0);
      chk("spur_tag_wr", tag_wr_en, 0);
      tick();
      spur = 1'b0;
      i_miss_addr = 16'hA5C0 + 16'(k * 16);
      i_miss = 1'b1;
      fill_run(OWN_I, 16'hA5C0 + 16'(k * 16), lat);
      tick();
      tick();
    end
    lat = 4;

    // Reset after the 3rd returned word
    i_miss_addr = 16'h1234;
    i_miss = 1'b1;
    for (int c = 1; c <= 7; c++) tick();
    chk("pre_rst_wr_en", data_wr_en, 1);
    chk("pre_rst_word", data_wr_word, 2);
    tick();
    i_miss = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    for (int c = 0; c < 12; c++) begin
      if (c == 2) rst_n = 1'b1;
      tick();
      chk("post_rst_wr_en", data_wr_en, 0);
      chk("post_rst_tag_wr", tag_wr_en, 0);
    end
    i_miss = 1'b1;
    fill_run(OWN_I, 16'h1234, 4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
